// File: rtl/shift_op_sequencer_if.sv
// Command/result handshake bundle for the multi-cycle shift unit.
// master: command producer / result consumer. slave: the shift unit.
// Ports: in_valid/in_ready/in_op/in_a/in_shamt (command), out_valid/out_ready/out_data (result).
interface shift_op_sequencer_if #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         in_op;
  logic [DATA_W-1:0]  in_a;
  logic [SHAMT_W-1:0] in_shamt;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_data;

  modport master (
    output in_valid, in_op, in_a, in_shamt, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_op, in_a, in_shamt, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/shift_op_sequencer.sv
// Multi-cycle SRL/SLL/SRA/ROR unit built around one shared logical-right barrel shifter.
// Latency: accept edge to out_valid is 2 cycles (SRL/SLL) or 3 cycles (SRA/ROR).
// Backpressure: one command in flight; in_ready only in IDLE, result held in DONE until out_ready.
// Ports: clk, rst_n (async active-low), bus (slave handshake), busy, done_cnt (wrapping count of result handshakes).
module shift_op_sequencer #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  shift_op_sequencer_if.slave bus,
  output logic               busy,
  output logic [CNT_W-1:0]   done_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PASS1 = 2'd1;
  localparam logic [1:0] S_PASS2 = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] OP_SRL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  logic [1:0]         state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [DATA_W-1:0]  a_q, a_d;
  logic [SHAMT_W-1:0] shamt_q, shamt_d;
  logic [DATA_W-1:0]  r1_q, r1_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Shared shifter operands; driven only from state and latched registers.
  logic [DATA_W-1:0]  sh_a;
  logic [SHAMT_W-1:0] sh_n;
  logic [DATA_W-1:0]  sh_out;
  logic               rev_out;
  logic [DATA_W-1:0]  pass_res;

  function automatic logic [DATA_W-1:0] bitrev(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) r[i] = x[DATA_W-1-i];
    return r;
  endfunction

  assign sh_out   = sh_a >> sh_n;
  assign pass_res = rev_out ? bitrev(sh_out) : sh_out;

  always_comb begin
    sh_a    = '0;
    sh_n    = '0;
    rev_out = 1'b0;
    case (state_q)
      S_PASS1: begin
        // Left shift is a right shift of the bit-reversed operand, reversed back.
        sh_n    = shamt_q;
        sh_a    = (op_q == OP_SLL) ? bitrev(a_q) : a_q;
        rev_out = (op_q == OP_SLL);
      end
      S_PASS2: begin
        if (op_q == OP_SRA) begin
          // Mask of the bits the logical shift kept; its complement is the sign fill.
          sh_a = '1;
          sh_n = shamt_q;
        end else begin
          // ROR wrap-around part: a << ((32 - n) mod 32); n=0 folds to a | a.
          sh_a    = bitrev(a_q);
          sh_n    = ~shamt_q + 1'b1;
          rev_out = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    shamt_d    = shamt_q;
    r1_d       = r1_q;
    out_data_d = out_data_q;
    cnt_d      = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          op_d    = bus.in_op;
          a_d     = bus.in_a;
          shamt_d = bus.in_shamt;
          state_d = S_PASS1;
        end
      end
      S_PASS1: begin
        r1_d = pass_res;
        if (op_q == OP_SRL || op_q == OP_SLL) begin
          out_data_d = pass_res;
          state_d    = S_DONE;
        end else begin
          state_d = S_PASS2;
        end
      end
      S_PASS2: begin
        if (op_q == OP_SRA) out_data_d = r1_q | (a_q[DATA_W-1] ? ~pass_res : '0);
        else                out_data_d = r1_q | pass_res;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      a_q        <= '0;
      shamt_q    <= '0;
      r1_q       <= '0;
      out_data_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      shamt_q    <= shamt_d;
      r1_q       <= r1_d;
      out_data_q <= out_data_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.out_data  = out_data_q;
  assign busy          = (state_q != S_IDLE);
  assign done_cnt      = cnt_q;

endmodule

// File: tb/tb_shift_op_sequencer.sv
// Directed bench for shift_op_sequencer: hand-computed results, latency,
// backpressure, async reset mid-operation, and counter wrap (narrow-counter instance).
module tb_shift_op_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  shift_op_sequencer_if #(.DATA_W(32), .SHAMT_W(5)) bus ();
  shift_op_sequencer_if #(.DATA_W(32), .SHAMT_W(5)) bus2 ();

  logic        busy, busy2;
  logic [15:0] done_cnt;
  logic [3:0]  done_cnt2;

  shift_op_sequencer #(.DATA_W(32), .SHAMT_W(5), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .done_cnt(done_cnt)
  );

  // Narrow counter copy so the wrap from all-ones to zero is reachable quickly.
  shift_op_sequencer #(.DATA_W(32), .SHAMT_W(5), .CNT_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2), .busy(busy2), .done_cnt(done_cnt2)
  );

  int vecs = 0;
  int miscmp = 0;
  logic [15:0] exp_cnt = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miscmp++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a command, scramble inputs after accept, wait for out_valid.
  // Latency counts rising edges with the accept edge as 1.
  task automatic issue(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [4:0] n, input logic [31:0] exp_data, input int exp_lat);
    int lat;
    @(negedge clk);
    chk({tag, " in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_shamt = n;
    @(negedge clk);
    lat = 1;
    bus.in_valid = 1'b0;
    bus.in_op    = ~op;
    bus.in_a     = ~a;
    bus.in_shamt = ~n;
    while (!bus.out_valid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " data"}, bus.out_data, exp_data);
  endtask

  task automatic handshake(input string tag);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    exp_cnt = exp_cnt + 16'd1;
    chk({tag, " valid drop"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, " done_cnt"}, {16'd0, done_cnt}, {16'd0, exp_cnt});
    chk({tag, " in_ready back"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    bus.in_valid = 1'b0; bus.in_op = 2'b00; bus.in_a = '0; bus.in_shamt = '0; bus.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_op = 2'b00; bus2.in_a = 32'h1; bus2.in_shamt = '0; bus2.out_ready = 1'b1;

    // Reset state
    #12;
    chk("rst out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst out_data", bus.out_data, 32'd0);
    chk("rst done_cnt", {16'd0, done_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // SRL
    issue("srl16", 2'b00, 32'h0000003F, 5'd16, 32'h00000000, 2); handshake("srl16");
    issue("srl1",  2'b00, 32'h0000003F, 5'd1,  32'h0000001F, 2); handshake("srl1");
    issue("srl0",  2'b00, 32'h0000003F, 5'd0,  32'h0000003F, 2); handshake("srl0");
    // SLL
    issue("sll3",  2'b01, 32'h0000003F, 5'd3,  32'h000001F8, 2); handshake("sll3");
    issue("sll31", 2'b01, 32'h00000001, 5'd31, 32'h80000000, 2); handshake("sll31");
    // SRA
    issue("sra_neg4", 2'b10, 32'h80000000, 5'd4,  32'hF8000000, 3); handshake("sra_neg4");
    issue("sra_pos4", 2'b10, 32'h7FFFFFF0, 5'd4,  32'h07FFFFFF, 3); handshake("sra_pos4");
    issue("sra_m31",  2'b10, 32'hFFFFFFFF, 5'd31, 32'hFFFFFFFF, 3); handshake("sra_m31");
    issue("sra_0",    2'b10, 32'h80000000, 5'd0,  32'h80000000, 3); handshake("sra_0");
    // ROR
    issue("ror4", 2'b11, 32'h0000003F, 5'd4, 32'hF0000003, 3); handshake("ror4");
    issue("ror0", 2'b11, 32'h0000003F, 5'd0, 32'h0000003F, 3); handshake("ror0");
    issue("ror1", 2'b11, 32'h00000001, 5'd1, 32'h80000000, 3); handshake("ror1");

    // Backpressure: hold result 5 cycles while a competing command is offered
    issue("bp", 2'b10, 32'h80000000, 5'd4, 32'hF8000000, 3);
    held = bus.out_data;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i < 2);
      bus.in_op    = 2'b00;
      bus.in_a     = 32'h12345678;
      bus.in_shamt = 5'd2;
      @(negedge clk);
      chk("bp hold valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp hold data", bus.out_data, held);
      chk("bp in_ready low", {31'd0, bus.in_ready}, 32'd0);
      chk("bp done_cnt frozen", {16'd0, done_cnt}, {16'd0, exp_cnt});
    end
    bus.in_valid = 1'b0;
    handshake("bp");
    repeat (3) @(negedge clk);
    chk("bp pulse ignored busy", {31'd0, busy}, 32'd0);
    chk("bp pulse ignored valid", {31'd0, bus.out_valid}, 32'd0);

    // Async reset in PASS2 of an SRA
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_op = 2'b10; bus.in_a = 32'h80000000; bus.in_shamt = 5'd4;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("mid busy before reset", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("arst in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("arst done_cnt", {16'd0, done_cnt}, 32'd0);
    chk("arst out_data", bus.out_data, 32'd0);
    exp_cnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post-reset no result", {31'd0, bus.out_valid}, 32'd0);
    chk("post-reset idle", {31'd0, busy}, 32'd0);
    issue("post-reset srl", 2'b00, 32'hF0000000, 5'd4, 32'h0F000000, 2); handshake("post-reset srl");

    // Counter wrap on the 4-bit instance (out_ready tied high there)
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      bus2.in_valid = 1'b1;
      @(negedge clk);
      bus2.in_valid = 1'b0;
      repeat (2) @(negedge clk);
    end
    chk("wrap all-ones", {28'd0, done_cnt2}, 32'h0000000F);
    @(negedge clk);
    bus2.in_valid = 1'b1;
    @(negedge clk);
    bus2.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("wrap to zero", {28'd0, done_cnt2}, 32'h00000000);
    chk("wrap last data", bus2.out_data, 32'h00000001);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end
endmodule
